// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin burst arbiter family: default
// field widths, the lock state encoding, the beat record and the index
// width helper used to size channel indices.
package arb_pkg;

   // Default field widths of the shared memory request port.
   localparam int ARB_ADDR_W = 27;
   localparam int ARB_DATA_W = 32;

   // Burst lock state. LOCK_HELD means a multi-beat burst is in flight and
   // only the owning channel may be granted until its last beat passes.
   typedef enum logic {
      LOCK_OPEN = 1'b0,
      LOCK_HELD = 1'b1
   } lock_state_e;

   // One beat as seen on the shared port at the default widths. Blocks that
   // override the widths declare the same record shape from their own
   // parameters.
   typedef struct packed {
      logic [ARB_ADDR_W-1:0] addr;
      logic [ARB_DATA_W-1:0] data;
      logic                  last;
   } beat_t;

   // ceil(log2(n)), but never less than 1 so a single channel still gets a
   // one-bit index.
   function automatic int clog2_min1(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: scans the request vector starting one
// position after ptr_i and wrapping at NUM_IN-1 -> 0, returning the first
// requester as a one-hot grant and as an index. Shared with the response
// router, so it carries no state of its own.
module rr_pick #(
   parameter int NUM_IN = 4,
   parameter int IDX_W  = 2
) (
   input  logic [NUM_IN-1:0] req_i,
   input  logic [IDX_W-1:0]  ptr_i,
   output logic [NUM_IN-1:0] grant_o,
   output logic [IDX_W-1:0]  grant_idx_o
);

   // First requester after ptr_i in circular order; no grant when idle.
   always_comb begin
      logic             found;
      logic [IDX_W-1:0] c;
      grant_o     = '0;
      grant_idx_o = '0;
      found       = 1'b0;
      c           = '0;
      for (int k = 1; k <= NUM_IN; k++) begin
         c = IDX_W'((int'(ptr_i) + k) % NUM_IN);
         if (!found && req_i[c]) begin
            grant_o[c]  = 1'b1;
            grant_idx_o = c;
            found       = 1'b1;
         end
      end
   end

endmodule

// File: rtl/rr_burst_arbiter.sv
// N-input round-robin arbiter with burst locking and a registered output
// slot. Multi-beat bursts are kept atomic: once a beat with last=0 is taken
// from a channel, that channel alone is served until its last beat. The
// pointer moves only at burst end, so fairness is counted in bursts.
module rr_burst_arbiter
   import arb_pkg::*;
#(
   parameter  int NUM_IN   = 4,
   parameter  int ADDR_W   = ARB_ADDR_W,
   parameter  int DATA_W   = ARB_DATA_W,
   localparam int CHOSEN_W = clog2_min1(NUM_IN)
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic [NUM_IN-1:0]          io_in_valid,
   output logic [NUM_IN-1:0]          io_in_ready,
   input  logic [NUM_IN*ADDR_W-1:0]   io_in_bits_addr,
   input  logic [NUM_IN*DATA_W-1:0]   io_in_bits_data,
   input  logic [NUM_IN-1:0]          io_in_bits_last,
   output logic                       io_out_valid,
   input  logic                       io_out_ready,
   output logic [ADDR_W-1:0]          io_out_bits_addr,
   output logic [DATA_W-1:0]          io_out_bits_data,
   output logic                       io_out_bits_last,
   output logic [CHOSEN_W-1:0]        io_chosen
);

   // Handshake: a beat moves across a port on a rising edge where valid and
   // ready are both high. Sources hold valid and the payload stable until
   // accepted. io_in_ready never looks at the same channel's io_in_valid,
   // only at the other channels' valids (through the round-robin order) and
   // at whether the output slot can take a beat this cycle.

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
      logic              last;
   } slot_t;

   // Registered state
   lock_state_e         state_q,     state_d;
   logic [CHOSEN_W-1:0] lock_idx_q,  lock_idx_d;
   logic [CHOSEN_W-1:0] ptr_q,       ptr_d;
   logic [CHOSEN_W-1:0] chosen_q,    chosen_d;
   slot_t               slot_q,      slot_d;
   logic                out_valid_q, out_valid_d;

   // Combinational helpers
   logic                slot_free;
   logic [NUM_IN-1:0]   pick_grant;
   logic [CHOSEN_W-1:0] pick_idx;
   logic [NUM_IN-1:0]   open_ready;
   logic [NUM_IN-1:0]   in_ready;
   logic [CHOSEN_W-1:0] sel_idx;
   logic                xfer;
   slot_t               in_beat;

   // The slot can be reloaded when empty or when its beat leaves this cycle.
   assign slot_free = ~out_valid_q | io_out_ready;

   rr_pick #(
      .NUM_IN (NUM_IN),
      .IDX_W  (CHOSEN_W)
   ) u_pick (
      .req_i       (io_in_valid),
      .ptr_i       (ptr_q),
      .grant_o     (pick_grant),
      .grant_idx_o (pick_idx)
   );

   // Unlocked offer mask: a channel is offered the slot when no valid
   // channel precedes it in round-robin order. Among valid channels this
   // singles out exactly the picker's winner, without using the channel's
   // own valid.
   always_comb begin
      logic                seen;
      logic [CHOSEN_W-1:0] c;
      open_ready = '0;
      seen       = 1'b0;
      c          = '0;
      for (int k = 1; k <= NUM_IN; k++) begin
         c             = CHOSEN_W'((int'(ptr_q) + k) % NUM_IN);
         open_ready[c] = ~seen;
         seen          = seen | io_in_valid[c];
      end
   end

   // Grant selection: a held lock pins the grant to the burst owner even
   // while it idles; otherwise the round-robin winner is served.
   always_comb begin
      in_ready = '0;
      sel_idx  = pick_idx;
      xfer     = 1'b0;
      if (state_q == LOCK_HELD) begin
         sel_idx              = lock_idx_q;
         in_ready[lock_idx_q] = slot_free;
         xfer                 = slot_free & io_in_valid[lock_idx_q];
      end else begin
         in_ready = open_ready & {NUM_IN{slot_free}};
         xfer     = slot_free & (|pick_grant);
      end
   end

   assign io_in_ready = in_ready;

   // Payload of the selected channel.
   always_comb begin
      in_beat.addr = io_in_bits_addr[sel_idx*ADDR_W +: ADDR_W];
      in_beat.data = io_in_bits_data[sel_idx*DATA_W +: DATA_W];
      in_beat.last = io_in_bits_last[sel_idx];
   end

   // Next state: load the slot on a transfer, update lock and pointer from
   // the beat's last flag, and empty the slot when it drains with no refill.
   always_comb begin
      state_d     = state_q;
      lock_idx_d  = lock_idx_q;
      ptr_d       = ptr_q;
      slot_d      = slot_q;
      chosen_d    = chosen_q;
      out_valid_d = out_valid_q;
      if (xfer) begin
         slot_d      = in_beat;
         chosen_d    = sel_idx;
         out_valid_d = 1'b1;
         if (in_beat.last) begin
            // Burst (or single beat) done: release and move the pointer so
            // this channel has lowest priority next time.
            state_d = LOCK_OPEN;
            ptr_d   = sel_idx;
         end else begin
            state_d    = LOCK_HELD;
            lock_idx_d = sel_idx;
         end
      end else if (io_out_ready) begin
         // Held fields are left as they are; only the valid drops.
         out_valid_d = 1'b0;
      end
   end

   // State registers. The pointer resets to the last channel so channel 0
   // is first in line; a reset drops any lock and the held beat.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= LOCK_OPEN;
         lock_idx_q  <= '0;
         ptr_q       <= CHOSEN_W'(NUM_IN - 1);
         chosen_q    <= '0;
         slot_q      <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         lock_idx_q  <= lock_idx_d;
         ptr_q       <= ptr_d;
         chosen_q    <= chosen_d;
         slot_q      <= slot_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign io_out_valid     = out_valid_q;
   assign io_out_bits_addr = slot_q.addr;
   assign io_out_bits_data = slot_q.data;
   assign io_out_bits_last = slot_q.last;
   assign io_chosen        = chosen_q;

endmodule

// File: tb/tb_rr_burst_arbiter.sv
// Directed bench for rr_burst_arbiter: a 4-input instance for fairness,
// burst locking, back-pressure, idle lock and asynchronous reset, plus a
// 3-input instance for pointer wrap on a non-power-of-two channel count.
module tb_rr_burst_arbiter;
   import arb_pkg::*;

   localparam int AW = 27;
   localparam int DW = 32;
   localparam int BW = 2 + AW + DW + 1;

   // Clock and reset
   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   // 4-input instance
   logic [3:0]      in_valid, in_ready, in_last;
   logic [4*AW-1:0] in_addr;
   logic [4*DW-1:0] in_data;
   logic            out_valid, out_ready, out_last;
   logic [AW-1:0]   out_addr;
   logic [DW-1:0]   out_data;
   logic [1:0]      chosen;

   // 3-input instance
   logic [2:0]      v3, r3, l3;
   logic [3*AW-1:0] a3;
   logic [3*DW-1:0] d3;
   logic            ov3, or3, ol3;
   logic [AW-1:0]   oa3;
   logic [DW-1:0]   od3;
   logic [1:0]      ch3;

   rr_burst_arbiter #(.NUM_IN(4), .ADDR_W(AW), .DATA_W(DW)) dut (
      .clock(clock), .reset(reset),
      .io_in_valid(in_valid), .io_in_ready(in_ready),
      .io_in_bits_addr(in_addr), .io_in_bits_data(in_data), .io_in_bits_last(in_last),
      .io_out_valid(out_valid), .io_out_ready(out_ready),
      .io_out_bits_addr(out_addr), .io_out_bits_data(out_data), .io_out_bits_last(out_last),
      .io_chosen(chosen)
   );

   rr_burst_arbiter #(.NUM_IN(3), .ADDR_W(AW), .DATA_W(DW)) dut3 (
      .clock(clock), .reset(reset),
      .io_in_valid(v3), .io_in_ready(r3),
      .io_in_bits_addr(a3), .io_in_bits_data(d3), .io_in_bits_last(l3),
      .io_out_valid(ov3), .io_out_ready(or3),
      .io_out_bits_addr(oa3), .io_out_bits_data(od3), .io_out_bits_last(ol3),
      .io_chosen(ch3)
   );

   // Scoreboard
   logic [BW-1:0] exp_q[$];
   logic [BW-1:0] exp3_q[$];
   logic [BW-1:0] e4, e3;
   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [BW-1:0] pack(input int ch, input logic [AW-1:0] a,
                                          input logic [DW-1:0] d, input logic l);
      return {2'(ch), a, d, l};
   endfunction

   // Driver tasks
   task automatic drive(input int ch, input logic v, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic l);
      in_valid[ch]         = v;
      in_addr[ch*AW +: AW] = a;
      in_data[ch*DW +: DW] = d;
      in_last[ch]          = l;
   endtask

   task automatic drive3(input int ch, input logic v, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic l);
      v3[ch]          = v;
      a3[ch*AW +: AW] = a;
      d3[ch*DW +: DW] = d;
      l3[ch]          = l;
   endtask

   // One clock: outputs are popped by the monitors at the negedge, then the
   // step resumes 1 ns after the next rising edge.
   task automatic tick();
      @(negedge clock);
      @(posedge clock);
      #1;
   endtask

   // Output monitors: a beat is consumed on the edge following a negedge
   // where valid and ready are both high.
   always @(negedge clock) begin
      if (!reset && out_valid && out_ready) begin
         if (exp_q.size() == 0) check("unexpected_beat4", 64'd1, 64'd0);
         else begin
            e4 = exp_q.pop_front();
            check("beat4", 64'({chosen, out_addr, out_data, out_last}), 64'(e4));
         end
      end
   end

   always @(negedge clock) begin
      if (!reset && ov3 && or3) begin
         if (exp3_q.size() == 0) check("unexpected_beat3", 64'd1, 64'd0);
         else begin
            e3 = exp3_q.pop_front();
            check("beat3", 64'({ch3, oa3, od3, ol3}), 64'(e3));
         end
      end
   end

   // Time bound
   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   int          g, other, exp_ptr;
   logic [3:0]  oh;
   logic [AW-1:0] a;
   logic [DW-1:0] d;

   initial begin
      in_valid = '0; in_last = '0; in_addr = '0; in_data = '0; out_ready = 1'b1;
      v3 = '0; l3 = '0; a3 = '0; d3 = '0; or3 = 1'b1;
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset = 1'b0;

      // Reset state
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_addr", 64'(out_addr), 64'd0);
      check("rst_data", 64'(out_data), 64'd0);
      check("rst_last", 64'(out_last), 64'd0);
      check("rst_chosen", 64'(chosen), 64'd0);
      check("rst_lock", 64'(dut.state_q), 64'(LOCK_OPEN));
      check("rst_ptr", 64'(dut.ptr_q), 64'd3);
      check("rst_ptr3", 64'(dut3.ptr_q), 64'd2);
      check("rst_out_valid3", 64'(ov3), 64'd0);
      @(posedge clock);
      #1;

      // All four channels valid with single beats: 0,1,2,3,0
      for (int k = 0; k < 5; k++) begin
         g = k % 4;
         for (int c = 0; c < 4; c++)
            drive(c, 1'b1, AW'(k*16 + c), 32'hA000_0000 | DW'(k*256 + c), 1'b1);
         #1;
         oh = 4'b0001 << g;
         check("t1_ready", 64'(in_ready), 64'(oh));
         exp_q.push_back(pack(g, AW'(k*16 + g), 32'hA000_0000 | DW'(k*256 + g), 1'b1));
         tick();
         check("t1_out_valid", 64'(out_valid), 64'd1);
         check("t1_chosen", 64'(chosen), 64'(g));
      end
      for (int c = 0; c < 4; c++) drive(c, 1'b0, '0, '0, 1'b0);
      tick();
      check("t1_drain", 64'(exp_q.size()), 64'd0);
      check("t1_out_idle", 64'(out_valid), 64'd0);

      // Channel 2 three-beat burst while 0 and 3 wait (pointer at 0)
      drive(0, 1'b1, AW'('h010), DW'('hB0), 1'b1);
      drive(3, 1'b1, AW'('h030), DW'('hB3), 1'b1);
      for (int b = 0; b < 3; b++) begin
         drive(2, 1'b1, AW'('h100 + 4*b), DW'('hC0 + b), (b == 2));
         #1;
         check("t2_rdy0", 64'(in_ready[0]), 64'd0);
         check("t2_rdy3", 64'(in_ready[3]), 64'd0);
         check("t2_rdy2", 64'(in_ready[2]), 64'd1);
         exp_q.push_back(pack(2, AW'('h100 + 4*b), DW'('hC0 + b), (b == 2)));
         tick();
         check("t2_chosen", 64'(chosen), 64'd2);
         if (b < 2) check("t2_lock", 64'(dut.state_q), 64'(LOCK_HELD));
      end
      drive(2, 1'b0, '0, '0, 1'b0);
      #1;
      check("t2_next3", 64'(in_ready[3]), 64'd1);
      check("t2_next3_not0", 64'(in_ready[0]), 64'd0);
      exp_q.push_back(pack(3, AW'('h030), DW'('hB3), 1'b1));
      tick();
      drive(3, 1'b0, '0, '0, 1'b0);
      #1;
      check("t2_then0", 64'(in_ready[0]), 64'd1);
      exp_q.push_back(pack(0, AW'('h010), DW'('hB0), 1'b1));
      tick();
      drive(0, 1'b0, '0, '0, 1'b0);
      tick();
      check("t2_drain", 64'(exp_q.size()), 64'd0);

      // Back-pressure: hold beat A for 5 cycles while channel 1 offers B
      drive(1, 1'b1, AW'('h200), DW'('hD1), 1'b1);
      #1;
      exp_q.push_back(pack(1, AW'('h200), DW'('hD1), 1'b1));
      tick();
      out_ready = 1'b0;
      drive(1, 1'b1, AW'('h204), DW'('hD2), 1'b1);
      for (int s = 0; s < 5; s++) begin
         #1;
         check("t3_hold_valid", 64'(out_valid), 64'd1);
         check("t3_hold_beat", 64'({chosen, out_addr, out_data, out_last}), 64'(exp_q[0]));
         check("t3_rdy", 64'(in_ready), 64'd0);
         tick();
      end
      out_ready = 1'b1;
      #1;
      check("t3_release_rdy1", 64'(in_ready[1]), 64'd1);
      exp_q.push_back(pack(1, AW'('h204), DW'('hD2), 1'b1));
      tick();
      drive(1, 1'b0, '0, '0, 1'b0);
      tick();
      check("t3_drain", 64'(exp_q.size()), 64'd0);

      // Locked channel 1 idles for 4 cycles while channel 0 is valid
      drive(1, 1'b1, AW'('h300), DW'('hE0), 1'b0);
      #1;
      exp_q.push_back(pack(1, AW'('h300), DW'('hE0), 1'b0));
      tick();
      drive(1, 1'b0, '0, '0, 1'b0);
      drive(0, 1'b1, AW'('h010), DW'('hF0), 1'b1);
      for (int s = 0; s < 4; s++) begin
         #1;
         check("t4_rdy", 64'(in_ready), 64'b0010);
         check("t4_lock", 64'(dut.state_q), 64'(LOCK_HELD));
         tick();
         check("t4_no_out", 64'(out_valid), 64'd0);
      end
      drive(1, 1'b1, AW'('h304), DW'('hE1), 1'b1);
      #1;
      check("t4_resume_rdy", 64'(in_ready), 64'b0010);
      exp_q.push_back(pack(1, AW'('h304), DW'('hE1), 1'b1));
      tick();
      check("t4_resume_chosen", 64'(chosen), 64'd1);
      drive(1, 1'b0, '0, '0, 1'b0);
      #1;
      check("t4_then0", 64'(in_ready[0]), 64'd1);
      exp_q.push_back(pack(0, AW'('h010), DW'('hF0), 1'b1));
      tick();
      drive(0, 1'b0, '0, '0, 1'b0);
      tick();
      check("t4_drain", 64'(exp_q.size()), 64'd0);

      // Asynchronous reset in the middle of a channel 2 burst
      drive(2, 1'b1, AW'('h400), DW'('h50), 1'b0);
      #1;
      exp_q.push_back(pack(2, AW'('h400), DW'('h50), 1'b0));
      tick();
      drive(2, 1'b1, AW'('h404), DW'('h51), 1'b0);
      #2;
      reset = 1'b1;
      #1;
      check("t5_async_valid", 64'(out_valid), 64'd0);
      check("t5_lock", 64'(dut.state_q), 64'(LOCK_OPEN));
      check("t5_ptr", 64'(dut.ptr_q), 64'd3);
      exp_q.delete();
      drive(2, 1'b0, '0, '0, 1'b0);
      @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      @(posedge clock);
      #1;
      drive(0, 1'b1, AW'('h500), DW'('h60), 1'b1);
      drive(2, 1'b1, AW'('h508), DW'('h62), 1'b1);
      #1;
      check("t5_prio0", 64'(in_ready), 64'b0001);
      exp_q.push_back(pack(0, AW'('h500), DW'('h60), 1'b1));
      tick();
      drive(0, 1'b1, AW'('h504), DW'('h61), 1'b1);
      #1;
      check("t5_then2", 64'(in_ready[2]), 64'd1);
      check("t5_not0", 64'(in_ready[0]), 64'd0);
      exp_q.push_back(pack(2, AW'('h508), DW'('h62), 1'b1));
      tick();
      drive(2, 1'b0, '0, '0, 1'b0);
      #1;
      exp_q.push_back(pack(0, AW'('h504), DW'('h61), 1'b1));
      tick();
      drive(0, 1'b0, '0, '0, 1'b0);
      tick();
      check("t5_drain", 64'(exp_q.size()), 64'd0);

      // Three channels, 1 and 2 always valid: 1,2,1,2,1,2
      exp_ptr = 2;
      for (int k = 0; k < 6; k++) begin
         g     = (k % 2 == 0) ? 1 : 2;
         other = 3 - g;
         a     = AW'('h600 + k);
         d     = DW'('h7000 + k);
         drive3(1, 1'b1, a, d, 1'b1);
         drive3(2, 1'b1, a, d, 1'b1);
         #1;
         check("t6_ptr", 64'(dut3.ptr_q), 64'(exp_ptr));
         check("t6_rdy_g", 64'(r3[g]), 64'd1);
         check("t6_rdy_other", 64'(r3[other]), 64'd0);
         exp3_q.push_back(pack(g, a, d, 1'b1));
         tick();
         check("t6_chosen", 64'(ch3), 64'(g));
         exp_ptr = g;
      end
      drive3(1, 1'b0, '0, '0, 1'b0);
      drive3(2, 1'b0, '0, '0, 1'b0);
      tick();
      check("t6_drain", 64'(exp3_q.size()), 64'd0);
      check("t6_ptr_final", 64'(dut3.ptr_q), 64'd2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
